// File: rtl/alu_pipe_div.sv
// ============================================================================
// Module   : alu_pipe_div
// Function : Parametrised ALU with valid/ready handshake and iterative divider
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] REM,
  output logic [3:0]       FLAGS,
  output logic             OUT_VALID
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_DIV  = 1'b1;
  localparam logic [WIDTH-1:0] ONES   = '1;
  localparam logic [WIDTH-1:0] MINV   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quot, prem, dvsr;

  logic [WIDTH-1:0] add_x, add_y, res;
  logic             add_cin, add_ovf, carry, ovf, divz;
  logic [WIDTH:0]   sum;

  logic [WIDTH:0]   rem_sh;
  logic             take;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  assign IN_READY = (state == S_IDLE);

  // All arithmetic ops share one WIDTH+1 adder: x + y + cin.
  always_comb begin
    add_x   = A;
    add_y   = '0;
    add_cin = 1'b0;
    case (INST)
      4'h0: add_cin = 1'b1;
      4'h1: add_y = ONES;
      4'h2: add_y = B;
      4'h3: begin add_y = ~B; add_cin = 1'b1; end
      4'h4, 4'h5: begin add_x = ~A; add_cin = 1'b1; end
      4'h7: begin add_x = ~B; add_cin = 1'b1; end
      default: ;
    endcase
    sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    divz  = 1'b0;
    case (INST)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        res = sum[WIDTH-1:0]; carry = sum[WIDTH]; ovf = add_ovf;
      end
      4'h4: begin
        if (A[WIDTH-1]) begin
          res = sum[WIDTH-1:0]; carry = sum[WIDTH]; ovf = (A == MINV);
        end else begin
          res = A;
        end
      end
      4'h5: begin res = sum[WIDTH-1:0]; carry = sum[WIDTH]; ovf = (A == MINV); end
      4'h6: begin res = ONES; divz = 1'b1; end  // only reached with B == 0
      4'h7: begin res = sum[WIDTH-1:0]; carry = sum[WIDTH]; ovf = (B == MINV); end
      4'h8: res = A & B;
      4'h9: res = A | B;
      4'hA: res = A ^ B;
      4'hB: res = ~B;
      4'hC: res = A;
      4'hD: res = ~A;
      4'hE: res = '0;
      4'hF: res = ONES;
      default: res = '0;
    endcase
  end

  // One restoring step; remainder stays below the divisor so it fits WIDTH bits.
  always_comb begin
    rem_sh  = {prem, quot[WIDTH-1]};
    take    = (rem_sh >= {1'b0, dvsr});
    rem_nx  = take ? (rem_sh[WIDTH-1:0] - dvsr) : rem_sh[WIDTH-1:0];
    quot_nx = {quot[WIDTH-2:0], take};
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      quot      <= '0;
      prem      <= '0;
      dvsr      <= '0;
      Z         <= '0;
      REM       <= '0;
      FLAGS     <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            if (INST == 4'h6 && B != '0) begin
              quot  <= A;
              prem  <= '0;
              dvsr  <= B;
              cnt   <= CNT_W'(WIDTH);
              state <= S_DIV;
            end else begin
              Z         <= res;
              FLAGS     <= {divz, (res == '0), carry, ovf};
              OUT_VALID <= 1'b1;
              if (INST == 4'h6) REM <= A;
            end
          end
        end
        S_DIV: begin
          quot <= quot_nx;
          prem <= rem_nx;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Z         <= quot_nx;
            REM       <= rem_nx;
            FLAGS     <= {1'b0, (quot_nx == '0), 2'b00};
            OUT_VALID <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_div.sv
// ============================================================================
// Module   : tb_alu_pipe_div
// Function : Directed self-checking bench for alu_pipe_div (WIDTH 32 and 8)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_pipe_div;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;

  logic        v32 = 1'b0, v8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  i32 = '0, i8 = '0;

  logic        rdy32, ov32, rdy8, ov8;
  logic [31:0] z32, r32;
  logic [7:0]  z8, r8;
  logic [3:0]  f32, f8;

  int total = 0;
  int bad   = 0;
  int busy;
  int pulses;

  always #5 CLOCK = ~CLOCK;

  alu_pipe_div #(.WIDTH(32)) dut32 (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(v32), .IN_READY(rdy32),
    .A(a32), .B(b32), .INST(i32), .Z(z32), .REM(r32), .FLAGS(f32), .OUT_VALID(ov32)
  );

  alu_pipe_div #(.WIDTH(8)) dut8 (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(v8), .IN_READY(rdy8),
    .A(a8), .B(b8), .INST(i8), .Z(z8), .REM(r8), .FLAGS(f8), .OUT_VALID(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    chk("rst_z", z32, 0);
    chk("rst_rem", r32, 0);
    chk("rst_flags", f32, 0);
    chk("rst_ov", ov32, 0);
    chk("rst_rdy", rdy32, 1);

    // ADD overflow
    v32 = 1; i32 = 4'h2; a32 = 32'h7FFF_FFFF; b32 = 32'h1;
    @(negedge CLOCK);
    chk("add_z", z32, 64'h8000_0000);
    chk("add_flags", f32, 4'b0001);
    chk("add_ov", ov32, 1);
    v32 = 0;
    @(negedge CLOCK);
    chk("add_ov_pulse", ov32, 0);
    chk("add_z_hold", z32, 64'h8000_0000);

    // SUB then DECA back-to-back
    v32 = 1; i32 = 4'h3; a32 = 32'd5; b32 = 32'd5;
    @(negedge CLOCK);
    chk("sub_z", z32, 0);
    chk("sub_flags", f32, 4'b0110);
    i32 = 4'h1; a32 = 32'd0;
    @(negedge CLOCK);
    chk("dec_z", z32, 64'hFFFF_FFFF);
    chk("dec_flags", f32, 4'b0000);
    chk("dec_ov", ov32, 1);

    // ABS most-negative, NEGA zero, ABS positive, NEGB, AND
    i32 = 4'h4; a32 = 32'h8000_0000;
    @(negedge CLOCK);
    chk("abs_min_z", z32, 64'h8000_0000);
    chk("abs_min_flags", f32, 4'b0001);
    i32 = 4'h5; a32 = 32'h0;
    @(negedge CLOCK);
    chk("neg0_z", z32, 0);
    chk("neg0_flags", f32, 4'b0110);
    i32 = 4'h4; a32 = 32'd5;
    @(negedge CLOCK);
    chk("abs_pos_z", z32, 5);
    chk("abs_pos_flags", f32, 4'b0000);
    i32 = 4'h7; b32 = 32'd1;
    @(negedge CLOCK);
    chk("negb_z", z32, 64'hFFFF_FFFF);
    chk("negb_flags", f32, 4'b0000);
    i32 = 4'h8; a32 = 32'h0000_F0F0; b32 = 32'h0000_FF00;
    @(negedge CLOCK);
    chk("and_z", z32, 64'h0000_F000);
    chk("and_flags", f32, 4'b0000);
    chk("rem_untouched", r32, 0);

    // Divide by zero
    i32 = 4'h6; a32 = 32'h1234; b32 = 32'h0;
    @(negedge CLOCK);
    chk("divz_z", z32, 64'hFFFF_FFFF);
    chk("divz_rem", r32, 64'h1234);
    chk("divz_flags", f32, 4'b1000);
    chk("divz_rdy", rdy32, 1);
    chk("divz_ov", ov32, 1);
    i32 = 4'hC; a32 = 32'h0;
    @(negedge CLOCK);
    chk("pass_z", z32, 0);
    chk("pass_flags", f32, 4'b0100);
    chk("pass_rem_hold", r32, 64'h1234);

    // DIV 100/7 with ignored IN_VALID during busy
    i32 = 4'h6; a32 = 32'd100; b32 = 32'd7;
    @(negedge CLOCK);
    chk("div_busy_ov", ov32, 0);
    chk("div_busy_z_hold", z32, 0);
    chk("div_busy_rem_hold", r32, 64'h1234);
    i32 = 4'h2; a32 = 32'd1; b32 = 32'd1;
    busy = 0; pulses = 0;
    while (!rdy32 && busy < 100) begin
      busy++;
      if (ov32) pulses++;
      @(negedge CLOCK);
    end
    v32 = 0;
    chk("div_busy_cycles", busy, 32);
    chk("div_early_pulses", pulses, 0);
    chk("div_ov", ov32, 1);
    chk("div_z", z32, 14);
    chk("div_rem", r32, 2);
    chk("div_flags", f32, 4'b0000);
    @(negedge CLOCK);
    chk("div_ov_single", ov32, 0);
    chk("div_ignored_z", z32, 14);

    // Reset during divide step ~10
    v32 = 1; i32 = 4'h6; a32 = 32'd100; b32 = 32'd7;
    @(negedge CLOCK);
    v32 = 0;
    repeat (9) @(negedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    chk("mrst_z", z32, 0);
    chk("mrst_rem", r32, 0);
    chk("mrst_flags", f32, 0);
    chk("mrst_ov", ov32, 0);
    chk("mrst_rdy", rdy32, 1);
    @(negedge CLOCK);
    RESET = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge CLOCK);
      if (ov32) pulses++;
    end
    chk("mrst_no_ov", pulses, 0);

    // WIDTH=8 divide and add
    v8 = 1; i8 = 4'h6; a8 = 8'hFF; b8 = 8'h10;
    @(negedge CLOCK);
    v8 = 0;
    busy = 0;
    while (!rdy8 && busy < 50) begin
      busy++;
      @(negedge CLOCK);
    end
    chk("div8_busy_cycles", busy, 8);
    chk("div8_ov", ov8, 1);
    chk("div8_z", z8, 8'h0F);
    chk("div8_rem", r8, 8'h0F);
    chk("div8_flags", f8, 4'b0000);
    v8 = 1; i8 = 4'h2; a8 = 8'hFF; b8 = 8'h01;
    @(negedge CLOCK);
    v8 = 0;
    chk("add8_z", z8, 0);
    chk("add8_flags", f8, 4'b0110);
    chk("add8_rem_hold", r8, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_pipe_div.md
Name: alu_pipe_div

Overview:
Parametrised successor to the 32-bit single-cycle ALU. It keeps the 4-bit INST encoding and registered-operand behaviour, and adds three things: a generic data width, a valid/ready input handshake with an output valid strobe, and a restored opcode 6 as a multi-cycle unsigned iterative divider with a remainder output. It sits between the operand-fetch stage and writeback of the functional unit.

Parameters:
WIDTH, 32, datapath width in bits; legal range 4..64.
CNT_W, $clog2(WIDTH+1), divide step counter width; derived, not overridden.

Ports:
CLOCK  input  1  single clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
IN_VALID  input  1  operands and opcode are presented this cycle.
IN_READY  output  1  block can accept; high only when the FSM is in IDLE (combinational from state).
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
INST  input  4  opcode (encoding below).
Z  output  WIDTH  registered result; holds its last value between results.
REM  output  WIDTH  registered divide remainder; updated only by opcode 6.
FLAGS  output  4  registered flags: [0] OVF, [1] CARRY, [2] ZERO, [3] DIVZ.
OUT_VALID  output  1  one-cycle pulse when Z/FLAGS carry a new result.

Behaviour:
- Reset (asynchronous, any time, including mid-divide):
  - Z=0, REM=0, FLAGS=0, OUT_VALID=0, FSM=IDLE, counter=0.
  - Any in-flight divide is discarded with no OUT_VALID.
- Accept occurs on an edge where IN_VALID & IN_READY. IN_VALID while busy is ignored, not queued.
- Opcodes (A/B treated as two's complement unless stated):
  - 0 A+1; 1 A-1; 2 A+B; 3 A-B; 4 abs(A); 5 -A; 6 A/B unsigned; 7 -B.
  - 8 A&B; 9 A|B; A A^B; B ~B; C A; D ~A; E all zeros; F all ones.
- Single-cycle ops (all except 6): result computed from A/B/INST at the accept edge and registered on that same edge. Z, FLAGS and OUT_VALID=1 are visible in the cycle after the accept edge. Back-to-back accepts give one result per cycle.
- Arithmetic: every op is a WIDTH+1-bit add of A and an operand/constant, with MSB = carry-out.
  - 0: A+1. 1: A+all-ones. 2: A+B. 3: A+~B+1. 4/5: ~A+1 (4 only when A[msb]=1; otherwise a pass with C=0, V=0). 7: ~B+1.
  - CARRY = carry-out. For SUB this means 1 = no borrow (A>=B unsigned).
  - OVF = signed overflow: sign of the result differs from the sign implied by the operands. For 4/5/7, OVF=1 iff the operand is the most-negative value.
- Logic ops 8..F: OVF=0, CARRY=0.
- ZERO = (Z==0) for every op, including 6.
- DIVZ = 0 for every op except 6.
- Divide FSM: IDLE, DIV.
  - IDLE: accept with INST=6 and B!=0 loads quotient-shift=A, partial remainder=0, divisor=B, counter=WIDTH, and goes to DIV.
  - DIV: each edge performs one restoring step (shift the {rem,quot} pair left by one, trial-subtract the divisor, keep the result if non-negative, set quot LSB) and decrements the counter.
  - The edge on which the counter goes 1->0 registers Z=quotient, REM=remainder, FLAGS={0,ZERO,0,0}, pulses OUT_VALID, and returns to IDLE.
  - Latency is WIDTH edges after accept. IN_READY is low for WIDTH cycles. The next accept is possible on edge WIDTH+1.
  - Z, REM and FLAGS hold their old values during DIV.
- Divide by zero (INST=6, B==0): no FSM entry. Single-cycle result Z=all ones, REM=A, FLAGS: DIVZ=1, ZERO=0, OVF=0, CARRY=0.
- REM is unchanged by opcodes other than 6.
- No X propagation: all registers are reset; the case statement fully covers INST.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF B=0x1 -> the cycle after the accept edge: Z=0x80000000, FLAGS=0b0001, OUT_VALID pulses for exactly 1 cycle.
- WIDTH=32, SUB A=5 B=5, then DECA A=0 on the next cycle -> Z=0 with FLAGS=0b0110, then Z=0xFFFFFFFF with FLAGS=0b0000 on consecutive cycles.
- WIDTH=32, DIV A=100 B=7 -> IN_READY low for 32 cycles, IN_VALID pulses during busy are ignored, then Z=14, REM=2, FLAGS=0b0000 with a single OUT_VALID.
- WIDTH=32, DIV A=0x1234 B=0 -> next cycle Z=0xFFFFFFFF, REM=0x1234, FLAGS=0b1000, IN_READY stays high.
- WIDTH=32, ABS A=0x80000000 and NEGA A=0 -> Z=0x80000000 with FLAGS=0b0001, then Z=0 with FLAGS=0b0110.
- RESET asserted mid-cycle during divide step 10 -> outputs are 0 immediately, no OUT_VALID, IN_READY=1. A following DIV 0xFF/0x10 on a WIDTH=8 instance gives Z=0x0F, REM=0x0F after 8 cycles. WIDTH=8 ADD 0xFF+0x01 -> Z=0, FLAGS=0b0110.
